// File: rtl/serial_bram_slave_pkg.sv
// Shared defaults, FSM state encoding and helpers for the serial bus BRAM slave.
package serial_bram_slave_pkg;

    localparam int DEF_ADDR_LEN  = 12;
    localparam int DEF_DATA_LEN  = 8;
    localparam int DEF_BURST_LEN = 12;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RFETCH,
        RDATA,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_bram_slave_bram_4k.sv
// Single-port inferred block RAM: synchronous write, registered read of the same address.
module bram_4k
    import serial_bram_slave_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int DATA_LEN = DEF_DATA_LEN
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata
);

    logic [DATA_LEN-1:0] mem [2**ADDR_LEN];

    // No reset on purpose: contents must survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/serial_bram_slave.sv
// Serial bus responder: deserialises address/burst/write data into a block RAM and serialises reads back.
module serial_bram_slave
    import serial_bram_slave_pkg::*;
#(
    parameter int ADDR_LEN  = DEF_ADDR_LEN,
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic read_en,
    input  logic write_en,
    input  logic master_valid,
    input  logic rx_address,
    input  logic rx_burst,
    input  logic rx_data,
    input  logic master_ready,
    output logic slave_ready,
    output logic slave_valid,
    output logic tx_data
);

    localparam int HDR_LEN = max_int(ADDR_LEN, BURST_LEN);
    localparam int HCW     = $clog2(HDR_LEN);
    localparam int BCW     = $clog2(DATA_LEN);
    localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_LEN - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_LEN - 1);

    state_t                state, next_state;
    logic [ADDR_LEN-1:0]   addr, addr_next;
    logic [BURST_LEN-1:0]  burst, burst_next;
    logic [BURST_LEN-1:0]  remaining;
    logic [HCW-1:0]        hdr_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_LEN-2:0]   wsh;
    logic                  is_write;
    logic                  ram_we;
    logic [DATA_LEN-1:0]   ram_wdata;
    logic [DATA_LEN-1:0]   rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        ram_we      = 1'b0;
        tx_data     = 1'b0;
        case (state)
            IDLE: begin
                slave_ready = 1'b1;
                if (master_valid && (read_en ^ write_en)) next_state = ADDR;
            end
            ADDR: begin
                slave_ready = 1'b1;
                if (master_valid && hdr_cnt == HDR_LAST) next_state = is_write ? WDATA : RFETCH;
            end
            WDATA: begin
                slave_ready = 1'b1;
                if (master_valid && bit_cnt == BIT_LAST) begin
                    ram_we = 1'b1;
                    if (remaining == BURST_LEN'(1)) next_state = DONE;
                end
            end
            RFETCH: next_state = RDATA;
            RDATA: begin
                slave_valid = 1'b1;
                tx_data     = rdata[bit_cnt];
                if (master_ready && bit_cnt == BIT_LAST)
                    next_state = (remaining > BURST_LEN'(1)) ? RFETCH : DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Header bits land by index so address and burst fields may differ in length.
    always_comb begin
        addr_next  = addr;
        burst_next = burst;
        if (int'(hdr_cnt) < ADDR_LEN)  addr_next[hdr_cnt]  = rx_address;
        if (int'(hdr_cnt) < BURST_LEN) burst_next[hdr_cnt] = rx_burst;
    end

    assign ram_wdata = {rx_data, wsh};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            burst     <= '0;
            remaining <= '0;
            hdr_cnt   <= '0;
            bit_cnt   <= '0;
            wsh       <= '0;
            is_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (master_valid && (read_en ^ write_en)) begin
                        addr     <= ADDR_LEN'(rx_address);
                        burst    <= BURST_LEN'(rx_burst);
                        hdr_cnt  <= HCW'(1);
                        is_write <= write_en;
                    end
                end
                ADDR: begin
                    if (master_valid) begin
                        addr    <= addr_next;
                        burst   <= burst_next;
                        hdr_cnt <= hdr_cnt + HCW'(1);
                        if (hdr_cnt == HDR_LAST) begin
                            hdr_cnt   <= '0;
                            bit_cnt   <= '0;
                            remaining <= (burst_next == '0) ? BURST_LEN'(1) : burst_next;
                        end
                    end
                end
                WDATA: begin
                    if (master_valid) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt   <= '0;
                            addr      <= addr + ADDR_LEN'(1);
                            remaining <= remaining - BURST_LEN'(1);
                        end else begin
                            wsh[bit_cnt] <= rx_data;
                            bit_cnt      <= bit_cnt + BCW'(1);
                        end
                    end
                end
                RDATA: begin
                    if (master_ready) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (remaining > BURST_LEN'(1)) begin
                                addr      <= addr + ADDR_LEN'(1);
                                remaining <= remaining - BURST_LEN'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    bram_4k #(
        .ADDR_LEN(ADDR_LEN),
        .DATA_LEN(DATA_LEN)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr),
        .wdata(ram_wdata),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_serial_bram_slave.sv
// Directed self-checking bench for serial_bram_slave: writes, bursts with wrap, stalls, gaps and resets.
module tb_serial_bram_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic read_en = 1'b0, write_en = 1'b0, master_valid = 1'b0;
    logic rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0, master_ready = 1'b1;
    logic slave_ready, slave_valid, tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    serial_bram_slave dut (
        .clk         (clk),
        .rst         (rst),
        .read_en     (read_en),
        .write_en    (write_en),
        .master_valid(master_valid),
        .rx_address  (rx_address),
        .rx_burst    (rx_burst),
        .rx_data     (rx_data),
        .master_ready(master_ready),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid),
        .tx_data     (tx_data)
    );

    always #5 clk = ~clk;

    // Header bits go out one per cycle; gap_at inserts two idle cycles before that bit.
    task automatic send_header(input logic [11:0] a, input logic [11:0] b, input bit wr, input int gap_at);
        for (int i = 0; i < 12; i++) begin
            if (i == gap_at) begin
                repeat (2) begin
                    @(negedge clk);
                    master_valid = 1'b0;
                end
            end
            @(negedge clk);
            write_en     = wr;
            read_en      = !wr;
            master_valid = 1'b1;
            rx_address   = a[i];
            rx_burst     = b[i];
        end
    endtask

    task automatic send_word(input logic [7:0] d, input int gap_at);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                repeat (2) begin
                    @(negedge clk);
                    master_valid = 1'b0;
                end
            end
            @(negedge clk);
            master_valid = 1'b1;
            rx_data      = d[i];
        end
    endtask

    task automatic recv_word(input bit toggle, output logic [7:0] w, output int vcyc,
                             output int hold_err, output bit tmo);
        int   k = 0;
        int   cyc = 0;
        logic rdy = 1'b1;
        logic prev_tx = 1'b0;
        bit   stalled = 1'b0;
        w = '0; vcyc = 0; hold_err = 0; tmo = 1'b0;
        while (k < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            master_ready = toggle ? rdy : 1'b1;
            if (slave_valid === 1'b1) begin
                vcyc++;
                if (stalled && tx_data !== prev_tx) hold_err++;
                if (master_ready) begin
                    w[k] = tx_data;
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_tx = tx_data;
                end
                if (toggle) rdy = ~rdy;
            end
        end
        if (k < 8) tmo = 1'b1;
    endtask

    // Observes the single DONE cycle followed by IDLE, clearing the request lines meanwhile.
    task automatic end_txn(output bit done_ok);
        @(negedge clk);
        master_valid = 1'b0;
        read_en      = 1'b0;
        write_en     = 1'b0;
        done_ok = (slave_ready === 1'b0) && (slave_valid === 1'b0);
        @(negedge clk);
        done_ok = done_ok && (slave_ready === 1'b1) && (slave_valid === 1'b0);
    endtask

    task automatic write_txn(input logic [11:0] a, input logic [11:0] b, input logic [2:0][7:0] d,
                             input int n, input int hgap, input int dgap, output bit done_ok);
        send_header(a, b, 1'b1, hgap);
        for (int k = 0; k < n; k++) send_word(d[k], (k == 0) ? dgap : -1);
        end_txn(done_ok);
    endtask

    task automatic read_txn(input logic [11:0] a, input logic [11:0] b, input int n, input bit toggle,
                            output logic [2:0][7:0] words, output int vcyc, output int herr,
                            output bit tmo, output bit done_ok);
        int  v, h;
        bit  t;
        words = '0; vcyc = 0; herr = 0; tmo = 1'b0;
        send_header(a, b, 1'b0, -1);
        for (int k = 0; k < n; k++) begin
            recv_word(toggle, words[k], v, h, t);
            vcyc += v;
            herr += h;
            tmo  |= t;
        end
        end_txn(done_ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (slave_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", slave_ready); end
        n_checks++;
        if (slave_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", slave_valid); end
        n_checks++;
        if (tx_data !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx: got %b want 0", tx_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] w;
        int  v, h;
        bit  t, ok;
        write_txn(12'h005, 12'd1, {8'h00, 8'h00, 8'hA5}, 1, -1, -1, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL single_wr_done: got %b want 1", ok); end
        send_header(12'h005, 12'd1, 1'b0, -1);
        @(negedge clk);
        n_checks++;
        if (slave_valid !== 1'b0 || slave_ready !== 1'b0)
            begin n_fail++; $display("[TB] FAIL single_rfetch: valid %b ready %b want 0 0", slave_valid, slave_ready); end
        recv_word(1'b0, w, v, h, t);
        n_checks++;
        if (w !== 8'hA5 || t) begin n_fail++; $display("[TB] FAIL single_rd_data: got %h tmo %b want a5", w, t); end
        n_checks++;
        if (v != 8) begin n_fail++; $display("[TB] FAIL single_rd_valid_cycles: got %0d want 8", v); end
        end_txn(ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rd_done: got %b want 1", ok); end
    endtask

    task automatic test_burst_wrap();
        logic [2:0][7:0] w;
        int  v, h;
        bit  t, ok;
        write_txn(12'hFFE, 12'd3, {8'h33, 8'h22, 8'h11}, 3, -1, -1, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_wr_done: got %b want 1", ok); end
        read_txn(12'hFFE, 12'd3, 3, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w !== {8'h33, 8'h22, 8'h11} || t)
            begin n_fail++; $display("[TB] FAIL wrap_rd_burst: got %h tmo %b want 332211", w, t); end
        n_checks++;
        if (ok !== 1'b1 || v != 24) begin n_fail++; $display("[TB] FAIL wrap_rd_done: done %b valid %0d want 1 24", ok, v); end
        read_txn(12'h000, 12'd1, 1, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w[0] !== 8'h33 || t) begin n_fail++; $display("[TB] FAIL wrap_addr0: got %h want 33", w[0]); end
    endtask

    task automatic test_ready_toggle();
        logic [2:0][7:0] w;
        int  v, h;
        bit  t, ok;
        write_txn(12'h010, 12'd1, {8'h00, 8'h00, 8'h3C}, 1, -1, -1, ok);
        read_txn(12'h010, 12'd1, 1, 1'b1, w, v, h, t, ok);
        n_checks++;
        if (w[0] !== 8'h3C || t) begin n_fail++; $display("[TB] FAIL toggle_data: got %h want 3c", w[0]); end
        n_checks++;
        if (h != 0) begin n_fail++; $display("[TB] FAIL toggle_hold: got %0d changes want 0", h); end
        n_checks++;
        if (v != 15) begin n_fail++; $display("[TB] FAIL toggle_valid_cycles: got %0d want 15", v); end
        read_txn(12'h010, 12'd1, 1, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w[0] !== 8'h3C || !ok) begin n_fail++; $display("[TB] FAIL toggle_reread: got %h done %b want 3c 1", w[0], ok); end
    endtask

    task automatic test_valid_gaps();
        logic [2:0][7:0] w;
        int  v, h;
        bit  t, ok;
        write_txn(12'h122, 12'd3, {8'h00, 8'h00, 8'h00}, 3, -1, -1, ok);
        write_txn(12'h123, 12'd1, {8'h00, 8'h00, 8'h5A}, 1, 5, 3, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL gaps_wr_done: got %b want 1", ok); end
        read_txn(12'h122, 12'd3, 3, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w !== {8'h00, 8'h5A, 8'h00} || t)
            begin n_fail++; $display("[TB] FAIL gaps_placement: got %h want 005a00", w); end
    endtask

    task automatic test_both_enables();
        logic [2:0][7:0] w;
        int  v, h, bad;
        bit  t, ok;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slave_ready !== 1'b1 || slave_valid !== 1'b0) bad++;
            read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1;
            rx_address = (i < 12) ? 1'(12'h005 >> i) : 1'b0;
            rx_burst   = (i == 0);
            rx_data    = 1'b1;
        end
        @(negedge clk);
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0) bad++;
        read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("[TB] FAIL both_en_idle: got %0d non-idle cycles want 0", bad); end
        read_txn(12'h005, 12'd1, 1, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w[0] !== 8'hA5 || t) begin n_fail++; $display("[TB] FAIL both_en_ram: got %h want a5", w[0]); end
        write_txn(12'h200, 12'd0, {8'h00, 8'h00, 8'h77}, 1, -1, -1, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL burst0_wr_done: got %b want 1", ok); end
        read_txn(12'h200, 12'd0, 1, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w[0] !== 8'h77 || !ok || v != 8)
            begin n_fail++; $display("[TB] FAIL burst0_rd: got %h done %b valid %0d want 77 1 8", w[0], ok, v); end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0][7:0] w;
        logic [7:0] w1;
        int  v, h;
        bit  t, ok;
        write_txn(12'h300, 12'd2, {8'h00, 8'hBB, 8'hAA}, 2, -1, -1, ok);
        send_header(12'h300, 12'd3, 1'b1, -1);
        send_word(8'h11, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_data = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0; master_valid = 1'b0; write_en = 1'b0;
        #1;
        n_checks++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0 || tx_data !== 1'b0)
            begin n_fail++; $display("[TB] FAIL rst_wr_outputs: got %b%b%b want 100", slave_ready, slave_valid, tx_data); end
        @(negedge clk);
        rst = 1'b1;
        read_txn(12'h300, 12'd2, 2, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w[1:0] !== {8'hBB, 8'h11} || !ok || t)
            begin n_fail++; $display("[TB] FAIL rst_wr_ram: got %h done %b want bb11", w[1:0], ok); end
        send_header(12'h300, 12'd3, 1'b0, -1);
        recv_word(1'b0, w1, v, h, t);
        n_checks++;
        if (w1 !== 8'h11 || t) begin n_fail++; $display("[TB] FAIL rst_rd_word1: got %h want 11", w1); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (slave_valid !== 1'b1 || tx_data !== 1'b1)
            begin n_fail++; $display("[TB] FAIL rst_rd_prestate: valid %b tx %b want 1 1", slave_valid, tx_data); end
        rst = 1'b0; master_valid = 1'b0; read_en = 1'b0;
        #1;
        n_checks++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0 || tx_data !== 1'b0)
            begin n_fail++; $display("[TB] FAIL rst_rd_outputs: got %b%b%b want 100", slave_ready, slave_valid, tx_data); end
        @(negedge clk);
        rst = 1'b1;
        read_txn(12'h301, 12'd1, 1, 1'b0, w, v, h, t, ok);
        n_checks++;
        if (w[0] !== 8'hBB || !ok || t) begin n_fail++; $display("[TB] FAIL rst_next_txn: got %h want bb", w[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_ready_toggle();
        test_valid_gaps();
        test_both_enables();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
